// File: rtl/series_ctrl_pkg.sv
// Shared types and constants for the Taylor-series evaluator controller.
package series_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StArm  = 3'd1,
        StInit = 3'd2,
        StMulq = 3'd3,
        StMulr = 3'd4,
        StAcc  = 3'd5,
        StDone = 3'd6
    } state_e;

    localparam logic [1:0] MODE_ALT = 2'b00;
    localparam logic [1:0] MODE_ADD = 2'b01;
    localparam logic [1:0] MODE_SUB = 2'b10;

endpackage

// File: rtl/series_phase_timer.sv
// Multiply-phase timer: counts 0..MUL_LAT-1 while enabled and flags the final cycle.
module series_phase_timer #(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam int unsigned TW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == TW'(MUL_LAT - 1));

endmodule

// File: rtl/series_eval_ctrl.sv
// Sequencer for the iterative Taylor-series datapath: init, x^2 multiply,
// coefficient multiply and accumulate for TERMS terms, with busy/done handshake and abort.
module series_eval_ctrl
    import series_ctrl_pkg::*;
#(
    parameter int unsigned TERMS   = 8,
    parameter int unsigned CNT_W   = 3,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Abort,
    input  logic [1:0]       Mode,
    output logic             sub,
    output logic             selx,
    output logic             selm,
    output logic             selq,
    output logic             selrom,
    output logic             selt,
    output logic             sela,
    output logic             ldq,
    output logic             ldt,
    output logic             lde,
    output logic             in0,
    output logic             inc,
    output logic [CNT_W-1:0] rom_addr,
    output logic [CNT_W-1:0] term_idx,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [1:0]       mode_q, mode_d;
    logic             in_mul, abort_act, last;

    assign in_mul    = (state_q == StMulq) || (state_q == StMulr);
    assign abort_act = Abort && (state_q != StIdle);

    // Clearing on the last cycle gives every multiply phase a fresh count from zero.
    series_phase_timer #(
        .MUL_LAT (MUL_LAT)
    ) u_timer (
        .Clk    (Clk),
        .Rst    (Rst),
        .clr_i  (!in_mul || last || abort_act),
        .en_i   (in_mul),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        sub     = 1'b0;
        selx    = 1'b0;
        selm    = 1'b0;
        selq    = 1'b0;
        selrom  = 1'b0;
        selt    = 1'b0;
        sela    = 1'b0;
        ldq     = 1'b0;
        ldt     = 1'b0;
        lde     = 1'b0;
        in0     = 1'b0;
        inc     = 1'b0;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (Start) begin
                    state_d = StArm;
                    mode_d  = Mode;
                end
            end
            StArm: begin
                if (!Start) state_d = StInit;
            end
            StInit: begin
                busy    = 1'b1;
                in0     = 1'b1;
                selx    = 1'b1;
                ldq     = 1'b1;
                lde     = 1'b1;
                ldt     = 1'b1;
                idx_d   = '0;
                state_d = StMulq;
            end
            StMulq: begin
                busy = 1'b1;
                selq = 1'b1;
                selt = 1'b1;
                selm = 1'b1;
                if (last) begin
                    ldt     = 1'b1;
                    state_d = StMulr;
                end
            end
            StMulr: begin
                busy   = 1'b1;
                selrom = 1'b1;
                selt   = 1'b1;
                selm   = 1'b1;
                if (last) begin
                    ldt     = 1'b1;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                busy = 1'b1;
                lde  = 1'b1;
                sela = 1'b1;
                inc  = 1'b1;
                case (mode_q)
                    MODE_ALT: sub = idx_q[0];
                    MODE_SUB: sub = 1'b1;
                    MODE_ADD: sub = 1'b0;
                    default:  sub = 1'b0;
                endcase
                if (idx_q == CNT_W'(TERMS - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = StMulq;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (abort_act) begin
            state_d = StIdle;
            idx_d   = '0;
            ldq     = 1'b0;
            ldt     = 1'b0;
            lde     = 1'b0;
            inc     = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            mode_q  <= MODE_ALT;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    assign term_idx = idx_q;
    assign rom_addr = idx_q;

endmodule
